// File: rtl/host_pkg.sv
// Shared types and helpers for the SRAM host sequencer: FSM state encoding,
// default widths and the result-row count rule.
package host_pkg;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_LOAD      = 4'd1,
        ST_RUN       = 4'd2,
        ST_WAIT_HI   = 4'd3,
        ST_WAIT_LO   = 4'd4,
        ST_DRAIN_REQ = 4'd5,
        ST_DRAIN_CAP = 4'd6,
        ST_DRAIN_OUT = 4'd7,
        ST_DONE      = 4'd8
    } host_state_e;

    // A valid convolution needs at least k_dim input rows; fewer rows produce nothing.
    function automatic logic [31:0] host_out_words(input logic [31:0] nrows, input int unsigned k_dim);
        logic [31:0] res;
        if (nrows >= 32'(k_dim)) begin
            res = nrows - 32'(k_dim) + 32'd1;
        end else begin
            res = 32'd0;
        end
        return res;
    endfunction

endpackage

// File: rtl/host_busy_watchdog.sv
// Busy-window watchdog: counts cycles spent waiting on the DUT and flags expiry.
// Only instantiated when HOST_TIMEOUT_EN is defined.
module host_busy_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic count_en_i,
    input  logic clear_i,
    output logic expired_o
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count while waiting; any state change restarts the window.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !count_en_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + CNT_W'(32'd1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = count_en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/sram_host_sequencer.sv
// Host sequencer: streams an image into the input SRAM, pulses the DUT, waits out
// its busy window and drains result rows. Busy watchdog enabled by HOST_TIMEOUT_EN.
module sram_host_sequencer
    import host_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned K_DIM          = 3,
    parameter int unsigned OUT_BASE       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic [ADDR_W-1:0] host_sram_write_address,
    output logic [DATA_W-1:0] host_sram_write_data,
    output logic              host_sram_write_enable,
    output logic              dut_run,
    input  logic              dut_busy,
    output logic [ADDR_W-1:0] host_sram_read_address,
    input  logic [DATA_W-1:0] sram_host_read_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              done,
    output logic              ovf_err,
    output logic              timeout_err
);
    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(32'd1);
    localparam logic [ADDR_W-1:0] OUT_BASE_A = ADDR_W'(OUT_BASE);

    host_state_e       state_q, state_d;
    logic              s_ready_q, s_ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic              run_q, run_d;
    logic [ADDR_W-1:0] ra_q, ra_d;
    logic              mv_q, mv_d;
    logic [DATA_W-1:0] md_q, md_d;
    logic              ml_q, ml_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              tmo_q, tmo_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              wfull_q, wfull_d;
    logic              first_q, first_d;
    logic [ADDR_W-1:0] nrows_q, nrows_d;
    logic [ADDR_W-1:0] out_words_q, out_words_d;
    logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;

    logic              hs_load_s, hs_m_s, is_last_s, waiting_s, expired_s;
    logic [ADDR_W-1:0] out_words_s;

    assign hs_load_s   = (state_q == ST_LOAD) && s_valid && s_ready_q;
    assign hs_m_s      = (state_q == ST_DRAIN_OUT) && mv_q && m_ready;
    assign is_last_s   = (rd_idx_q == (out_words_q - ONE_A));
    assign waiting_s   = (state_q == ST_WAIT_HI) || (state_q == ST_WAIT_LO);
    assign out_words_s = ADDR_W'(host_out_words(32'(nrows_q), K_DIM));

`ifdef HOST_TIMEOUT_EN
    host_busy_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .reset      (reset),
        .count_en_i (waiting_s),
        .clear_i    (state_d != state_q),
        .expired_o  (expired_s)
    );
`else
    logic tmo_unused_s;
    assign tmo_unused_s = (TIMEOUT_CYCLES == 32'd0);
    assign expired_s    = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (host_start) state_d = ST_LOAD; else state_d = ST_IDLE;
            ST_LOAD:      if (hs_load_s && s_last) state_d = ST_RUN; else state_d = ST_LOAD;
            ST_RUN:       state_d = ST_WAIT_HI;
            ST_WAIT_HI: begin
                if (expired_s)     state_d = ST_DONE;
                else if (dut_busy) state_d = ST_WAIT_LO;
                else               state_d = ST_WAIT_HI;
            end
            ST_WAIT_LO: begin
                if (expired_s)                 state_d = ST_DONE;
                else if (dut_busy)             state_d = ST_WAIT_LO;
                else if (out_words_s == '0)    state_d = ST_DONE;
                else                           state_d = ST_DRAIN_REQ;
            end
            ST_DRAIN_REQ: state_d = ST_DRAIN_CAP;
            ST_DRAIN_CAP: state_d = ST_DRAIN_OUT;
            ST_DRAIN_OUT: begin
                if (!hs_m_s)       state_d = ST_DRAIN_OUT;
                else if (is_last_s) state_d = ST_DONE;
                else               state_d = ST_DRAIN_REQ;
            end
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; strobes are decoded from the next state so they leave a flop.
    always_comb begin
        s_ready_d   = (state_d == ST_LOAD);
        run_d       = (state_d == ST_RUN);
        mv_d        = (state_d == ST_DRAIN_OUT);
        ml_d        = (state_d == ST_DRAIN_OUT) && is_last_s;
        done_d      = (state_d == ST_DONE);
        we_d        = 1'b0;
        wa_d        = wa_q;
        wd_d        = wd_q;
        ra_d        = ra_q;
        md_d        = md_q;
        ovf_d       = ovf_q;
        tmo_d       = tmo_q;
        waddr_d     = waddr_q;
        wfull_d     = wfull_q;
        first_d     = first_q;
        nrows_d     = nrows_q;
        out_words_d = out_words_q;
        rd_idx_d    = rd_idx_q;

        if ((state_q == ST_IDLE) && host_start) begin
            ovf_d   = 1'b0;
            tmo_d   = 1'b0;
            waddr_d = '0;
            wfull_d = 1'b0;
            first_d = 1'b1;
        end else if (hs_load_s) begin
            if (first_q) begin
                nrows_d = s_data[ADDR_W-1:0];
                first_d = 1'b0;
            end else begin
                first_d = 1'b0;
            end
            // Past the top of the SRAM words are swallowed rather than wrapping.
            if (wfull_q) begin
                ovf_d = 1'b1;
            end else begin
                we_d = 1'b1;
                wa_d = waddr_q;
                wd_d = s_data;
                if (waddr_q == ADDR_MAX) wfull_d = 1'b1; else waddr_d = waddr_q + ONE_A;
            end
        end else if (waiting_s && expired_s) begin
            tmo_d = 1'b1;
        end else if ((state_q == ST_WAIT_LO) && (state_d == ST_DRAIN_REQ)) begin
            ra_d        = OUT_BASE_A;
            rd_idx_d    = '0;
            out_words_d = out_words_s;
        end else if (state_q == ST_DRAIN_CAP) begin
            md_d = sram_host_read_data;
        end else if (hs_m_s) begin
            ra_d     = ra_q + ONE_A;
            rd_idx_d = rd_idx_q + ONE_A;
        end else begin
            we_d = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            s_ready_q   <= 1'b0;
            we_q        <= 1'b0;
            wa_q        <= '0;
            wd_q        <= '0;
            run_q       <= 1'b0;
            ra_q        <= '0;
            mv_q        <= 1'b0;
            md_q        <= '0;
            ml_q        <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            tmo_q       <= 1'b0;
            waddr_q     <= '0;
            wfull_q     <= 1'b0;
            first_q     <= 1'b0;
            nrows_q     <= '0;
            out_words_q <= '0;
            rd_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            s_ready_q   <= s_ready_d;
            we_q        <= we_d;
            wa_q        <= wa_d;
            wd_q        <= wd_d;
            run_q       <= run_d;
            ra_q        <= ra_d;
            mv_q        <= mv_d;
            md_q        <= md_d;
            ml_q        <= ml_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            tmo_q       <= tmo_d;
            waddr_q     <= waddr_d;
            wfull_q     <= wfull_d;
            first_q     <= first_d;
            nrows_q     <= nrows_d;
            out_words_q <= out_words_d;
            rd_idx_q    <= rd_idx_d;
        end
    end

    assign s_ready                 = s_ready_q;
    assign host_sram_write_address = wa_q;
    assign host_sram_write_data    = wd_q;
    assign host_sram_write_enable  = we_q;
    assign dut_run                 = run_q;
    assign host_sram_read_address  = ra_q;
    assign m_valid                 = mv_q;
    assign m_data                  = md_q;
    assign m_last                  = ml_q;
    assign done                    = done_q;
    assign ovf_err                 = ovf_q;
    assign timeout_err             = tmo_q;

endmodule

// File: tb/tb_sram_host_sequencer.sv
// Self-checking bench for sram_host_sequencer: table-driven jobs, random jobs
// against a count/array model, overflow and mid-load reset sequences.
module tb_sram_host_sequencer;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam int KD = 3;
    localparam int OB = 0;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset, host_start, s_valid, s_ready, s_last;
    logic [DW-1:0] s_data;
    logic [AW-1:0] host_sram_write_address, host_sram_read_address;
    logic [DW-1:0] host_sram_write_data, sram_host_read_data, m_data;
    logic          host_sram_write_enable, dut_run, dut_busy;
    logic          m_valid, m_ready, m_last, done, ovf_err, timeout_err;

    int n_cmp = 0;
    int n_err = 0;
    int wr_total = 0;
    int run_total = 0;

    logic [DW-1:0] osram [0:DEPTH-1];

    sram_host_sequencer #(.ADDR_W(AW), .DATA_W(DW), .K_DIM(KD), .OUT_BASE(OB), .TIMEOUT_CYCLES(4096)) dut (
        .clk(clk), .reset(reset), .host_start(host_start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .host_sram_write_address(host_sram_write_address),
        .host_sram_write_data(host_sram_write_data),
        .host_sram_write_enable(host_sram_write_enable),
        .dut_run(dut_run), .dut_busy(dut_busy),
        .host_sram_read_address(host_sram_read_address),
        .sram_host_read_data(sram_host_read_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .done(done), .ovf_err(ovf_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) sram_host_read_data <= osram[host_sram_read_address];

    always @(negedge clk) begin
        if (host_sram_write_enable === 1'b1) wr_total <= wr_total + 1;
        if (dut_run === 1'b1) run_total <= run_total + 1;
    end

    typedef struct {
        int          nwords;
        logic [15:0] nrows;
        int          busy_len;
        int          ready_mode;
        int          exp_out;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int ref_out_words(input logic [15:0] nrows_w);
        int n;
        n = int'(nrows_w) % DEPTH;
        return (n >= KD) ? n - KD + 1 : 0;
    endfunction

    // One complete host transaction: load, DUT busy window, drain.
    task automatic run_job(input int nwords, input logic [15:0] nrows_w, input int busy_len,
                           input int ready_mode, input bit valid_gaps, input int exp_out, input string tag);
        int            wr0, run0, idx, stall, budget, n_exp_wr;
        logic [DW-1:0] word;
        bit            r;
        n_exp_wr = (nwords > DEPTH) ? DEPTH : nwords;
        @(negedge clk);
        wr0 = wr_total; run0 = run_total;
        host_start = 1'b1;
        @(negedge clk);
        host_start = 1'b0;
        check({tag, "_ovf_clr"}, 32'(ovf_err), 32'd0);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
        for (int i = 0; i < nwords; i++) begin
            if (valid_gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    s_valid = 1'b0;
                    @(negedge clk);
                end
            end
            word = (i == 0) ? nrows_w : DW'($urandom);
            s_valid = 1'b1; s_data = word; s_last = (i == nwords - 1);
            @(negedge clk);
            if (i < DEPTH) begin
                if (i < 8 || i == DEPTH - 1) begin
                    check({tag, "_we"}, 32'(host_sram_write_enable), 32'd1);
                    check({tag, "_waddr"}, 32'(host_sram_write_address), 32'(i));
                    check({tag, "_wdata"}, 32'(host_sram_write_data), 32'(word));
                end
            end else begin
                check({tag, "_we_ovf"}, 32'(host_sram_write_enable), 32'd0);
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
        check({tag, "_run_rise"}, 32'(dut_run), 32'd1);
        @(negedge clk);
        check({tag, "_run_once"}, 32'(dut_run), 32'd0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        dut_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        dut_busy = 1'b0;
        if (exp_out == 0) begin
            @(negedge clk);
            check({tag, "_done_nodrain"}, 32'(done), 32'd1);
            check({tag, "_no_mvalid"}, 32'(m_valid), 32'd0);
        end else begin
            @(negedge clk);
            check({tag, "_mv_lat1"}, 32'(m_valid), 32'd0);
            @(negedge clk);
            check({tag, "_mv_lat2"}, 32'(m_valid), 32'd0);
            @(negedge clk);
            check({tag, "_mv_lat3"}, 32'(m_valid), 32'd1);
            idx = 0; stall = 0; budget = 0;
            while (idx < exp_out && budget < 4000) begin
                budget++;
                if (m_valid === 1'b1) begin
                    check({tag, "_mdata"}, 32'(m_data), 32'(osram[OB + idx]));
                    check({tag, "_mlast"}, 32'(m_last), 32'(idx == exp_out - 1));
                    case (ready_mode)
                        0: r = 1'b1;
                        1: r = ($urandom_range(0, 1) == 1);
                        default: begin
                            r = !(idx == 1 && stall < 5);
                            if (!r) stall++;
                        end
                    endcase
                    m_ready = r;
                    if (r) idx++;
                end else begin
                    m_ready = 1'b0;
                end
                @(negedge clk);
            end
            m_ready = 1'b0;
            if (idx < exp_out) check({tag, "_drain_timeout"}, 32'(idx), 32'(exp_out));
            check({tag, "_done_after_last"}, 32'(done), 32'd1);
            check({tag, "_mv_after_last"}, 32'(m_valid), 32'd0);
        end
        @(negedge clk);
        check({tag, "_done_once"}, 32'(done), 32'd0);
        @(negedge clk);
        check({tag, "_writes"}, 32'(wr_total - wr0), 32'(n_exp_wr));
        check({tag, "_runs"}, 32'(run_total - run0), 32'd1);
        check({tag, "_ovf"}, 32'(ovf_err), 32'(nwords > DEPTH));
        check({tag, "_tmo"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        vec_t vecs[7];
        int   nw, nb;
        logic [15:0] nr;
        vecs[0] = '{7, 16'd6,     20, 0, 4};
        vecs[1] = '{3, 16'd2,      5, 0, 0};
        vecs[2] = '{4, 16'd3,      3, 0, 1};
        vecs[3] = '{1, 16'd0,      2, 0, 0};
        vecs[4] = '{5, 16'hF005,   4, 0, 3};
        vecs[5] = '{6, 16'd5,      6, 2, 3};
        vecs[6] = '{2, 16'd4,      1, 1, 2};

        for (int i = 0; i < DEPTH; i++) osram[i] = (i < 4) ? 16'hA001 + 16'(i) : 16'($urandom);

        reset = 1'b1; host_start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        dut_busy = 1'b0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_we", 32'(host_sram_write_enable), 32'd0);
        check("rst_outs", 32'({s_ready, dut_run, m_valid, m_last, done, ovf_err, timeout_err}), 32'd0);
        check("rst_addr", 32'({host_sram_write_address, host_sram_read_address}), 32'd0);
        check("rst_data", 32'({host_sram_write_data, m_data}), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_job(vecs[i].nwords, vecs[i].nrows, vecs[i].busy_len, vecs[i].ready_mode, 1'b0,
                    vecs[i].exp_out, $sformatf("vec%0d", i));

        run_job(DEPTH + 1, 16'd2, 3, 0, 1'b0, 0, "ovf");

        for (int j = 0; j < 10; j++) begin
            nw = $urandom_range(1, 12);
            nr = 16'($urandom_range(0, 12));
            nb = $urandom_range(1, 10);
            run_job(nw, nr, nb, 1, 1'b1, ref_out_words(nr), $sformatf("rnd%0d", j));
        end

        // Reset in the middle of a load must kill the pending write and return to idle.
        @(negedge clk);
        host_start = 1'b1;
        @(negedge clk);
        host_start = 1'b0;
        s_valid = 1'b1; s_data = 16'd9; s_last = 1'b0;
        @(negedge clk);
        s_data = 16'h1234;
        @(negedge clk);
        check("mid_load_we", 32'(host_sram_write_enable), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_async_we", 32'(host_sram_write_enable), 32'd0);
        check("rst_async_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_we", 32'(host_sram_write_enable), 32'd0);
            check("post_rst_idle", 32'(s_ready), 32'd0);
        end
        s_valid = 1'b0;

        run_job(7, 16'd6, 8, 0, 1'b0, 4, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_host_sequencer.md
# sram_host_sequencer

Host-side sequencer at the opposite end of the convolution DUT's memory interface. Accepts an input image as a valid/ready word stream and writes it into the input SRAM, then starts the DUT and waits out its busy window. Afterwards it reads the result rows back from the output SRAM and emits them as a valid/ready stream. Sits in the testbench/SoC wrapper between the host stream and the two SRAMs the DUT uses.

## Interface
- ADDR_W, 12, SRAM address width
- DATA_W, 16, SRAM/stream word width
- K_DIM, 3, kernel dimension; output rows = input rows − (K_DIM−1)
- OUT_BASE, 0, first output-SRAM address read during drain
- TIMEOUT_CYCLES, 4096, busy watchdog limit (only with HOST_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- host_start  in  1  one-cycle pulse; honoured only in IDLE
- s_valid / s_ready  in / out  1 / 1  load-stream handshake
- s_data  in  DATA_W  load word; first word = nrows
- s_last  in  1  marks final load word
- host_sram_write_address  out  ADDR_W  input-SRAM write address
- host_sram_write_data  out  DATA_W  input-SRAM write data
- host_sram_write_enable  out  1  input-SRAM write strobe
- dut_run  out  1  one-cycle DUT start pulse
- dut_busy  in  1  DUT busy flag
- host_sram_read_address  out  ADDR_W  output-SRAM read address
- sram_host_read_data  in  DATA_W  output-SRAM data, 1-cycle latency
- m_valid / m_ready  out / in  1 / 1  result-stream handshake
- m_data  out  DATA_W  result word
- m_last  out  1  marks final result word
- done  out  1  one-cycle completion pulse
- ovf_err  out  1  sticky: load exceeded 2^ADDR_W words
- timeout_err  out  1  sticky: busy watchdog expired

## Operation
- States: IDLE, LOAD, RUN, WAIT_HI, WAIT_LO, DRAIN_REQ, DRAIN_CAP, DRAIN_OUT, DONE.
- IDLE: s_ready=0. On host_start, clear ovf_err, timeout_err, and the write address, then go to LOAD.
- LOAD: s_ready=1. Each handshake registers data/address and asserts write_enable on the next cycle. The address then increments.
  - The first handshaked word is captured as nrows.
  - A handshake with s_last goes to RUN.
- LOAD overflow: after address 2^ADDR_W−1 has been written, later words are still accepted but not written, and ovf_err is set. The address does not wrap.
- RUN: dut_run=1 for exactly one cycle, then WAIT_HI.
- WAIT_HI waits for dut_busy=1, then goes to WAIT_LO. WAIT_LO waits for dut_busy=0.
- Leaving WAIT_LO: out_words = nrows−K_DIM+1 if nrows≥K_DIM, else 0. If out_words is 0, go to DONE with no m_valid. Otherwise set the read address to OUT_BASE and go to DRAIN_REQ.
- DRAIN_REQ presents the address and goes to DRAIN_CAP. DRAIN_CAP registers sram_host_read_data into m_data and goes to DRAIN_OUT.
- DRAIN_OUT: m_valid=1, and m_data stays stable until m_ready.
  - m_last=1 on word out_words−1.
  - On handshake, increment the read address. Go to DRAIN_REQ, or to DONE after the last word.
- DONE: done=1 for one cycle, then IDLE. ovf_err and timeout_err hold until the next accepted host_start.
- host_start outside IDLE is ignored. s_valid outside LOAD is ignored.
- Arithmetic: the word count is unsigned ADDR_W bits and nrows is truncated to ADDR_W.

## Timing
- Reset values: all outputs 0, and the FSM is in IDLE. Asserting reset mid-operation drops write_enable, dut_run and m_valid asynchronously. No partial write may follow reset release.
- Load write latency: handshake in cycle N gives write_enable=1 in cycle N+1 with that word. Sustained rate is 1 word/cycle.
- dut_run rises on the cycle after the s_last handshake.
- Drain: 3 cycles minimum per word (REQ, CAP, OUT). First m_valid comes 3 cycles after dut_busy falls.
- done is asserted one cycle after the final m handshake, or one cycle after dut_busy falls when out_words=0.

## Configuration
- HOST_TIMEOUT_EN defined:
  - A counter runs in WAIT_HI and WAIT_LO and clears on every state change.
  - Reaching TIMEOUT_CYCLES sets timeout_err and goes to DONE with no drain.
- Not defined: WAIT_HI and WAIT_LO wait indefinitely, timeout_err is tied to 0, and the counter logic is absent.

## Structure
- Shared package host_pkg holds: the state enum, ADDR_W/DATA_W defaults, and the out_words computation function.
- One sub-module is natural: host_busy_watchdog, containing the counter and the compare. It is instantiated only under HOST_TIMEOUT_EN.

## Test plan
- Load [6, 0x0003, …, 0x003F] (7 words, s_last on the 7th) → writes at addresses 0–6 in order. dut_run pulses once, on the cycle after the last handshake.
- dut_busy high for 20 cycles, then low. Output SRAM words 0–3 = 0xA001..0xA004 → four m words in order with m_last on 0xA004, then done one cycle later.
- nrows=2 → no m_valid, and done 1 cycle after dut_busy falls.
- m_ready low for 5 cycles during word 1 → m_data stays stable and no address skips.
- Loading 4097 words → 4096 writes, ovf_err=1, and ovf_err cleared by the next host_start.
- With HOST_TIMEOUT_EN and TIMEOUT_CYCLES=16, dut_busy never rises → timeout_err=1 and done pulses. Reset asserted mid-LOAD → write_enable=0 immediately and FSM in IDLE.
